// File: rtl/pong_game_sequencer_if.sv
// Handshake bundle between the match sequencer and the shared game-state datapath.
// Latency: none, wires only.
// Backpressure: each req is held until its ack; the slave side returns acks and ball-exit flags.
interface pong_game_sequencer_if;
  logic pad_req;
  logic pad_ack;
  logic ball_req;
  logic ball_ack;
  logic ball_out_l;
  logic ball_out_r;
  logic ai_req;
  logic ai_ack;

  modport master (
    output pad_req, ball_req, ai_req,
    input  pad_ack, ball_ack, ball_out_l, ball_out_r, ai_ack
  );

  modport slave (
    input  pad_req, ball_req, ai_req,
    output pad_ack, ball_ack, ball_out_l, ball_out_r, ai_ack
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong match controller: idle/serve/play/point/over FSM, per-game-tick pad->ball->ai step sequencer, score.
// Latency: all outputs registered; a req rises one cycle after its trigger and drops one cycle after its ack.
// Backpressure: a req holds until acked; game ticks arriving mid-sequence are dropped and flagged on tick_overrun.
// Optional feature: define PONG_SEQ_PAUSE_EN to add a pause input that freezes serve/play timing.
module pong_game_sequencer #(
  parameter int FRAME_DIV    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  start,
`ifdef PONG_SEQ_PAUSE_EN
  input  logic                  pause,
`endif
  pong_game_sequencer_if.master dp,
  output logic                  ball_center,
  output logic [7:0]            score,
  output logic                  game_over,
  output logic [2:0]            state,
  output logic                  tick_overrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SS_WAIT = 2'd0,
    SS_PAD  = 2'd1,
    SS_BALL = 2'd2,
    SS_AI   = 2'd3
  } step_e;

  localparam logic [5:0] DIV_LAST   = 6'(FRAME_DIV - 1);
  localparam logic [7:0] SERVE_LOAD = 8'(SERVE_FRAMES);
  localparam logic [3:0] WIN_NIB    = 4'(WIN_SCORE);

  state_e      state_q, state_d;
  step_e       step_q, step_d;
  logic [5:0]  div_q, div_d;
  logic [7:0]  serve_q, serve_d;
  logic        start_q, start_d;
  logic        pad_req_q, pad_req_d;
  logic        ball_req_q, ball_req_d;
  logic        ai_req_q, ai_req_d;
  logic        ball_center_q, ball_center_d;
  logic [7:0]  score_q, score_d;
  logic        game_over_q, game_over_d;
  logic        tick_overrun_q, tick_overrun_d;
  logic        pt_l_q, pt_l_d;
  logic        pt_r_q, pt_r_d;

  logic        hold;
  logic        start_rise;
  logic        frame_en;
  logic        game_tick;
  logic [3:0]  nib_p;
  logic [3:0]  nib_o;

`ifdef PONG_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign start_rise = start & ~start_q;
  assign frame_en   = frame_tick & ~hold;
  assign nib_p      = score_q[3:0] + 4'd1;
  assign nib_o      = score_q[7:4] + 4'd1;

  // Next-state logic for the match FSM, step sequencer, counters and score.
  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    div_d          = div_q;
    serve_d        = serve_q;
    start_d        = start;
    pad_req_d      = pad_req_q;
    ball_req_d     = ball_req_q;
    ai_req_d       = ai_req_q;
    score_d        = score_q;
    game_over_d    = game_over_q;
    tick_overrun_d = 1'b0;
    pt_l_d         = pt_l_q;
    pt_r_d         = pt_r_q;
    game_tick      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          score_d = 8'h00;
          serve_d = SERVE_LOAD;
          state_d = ST_SERVE;
        end
      end

      ST_SERVE: begin
        // The tick that empties the counter starts play with a fresh divider.
        if (frame_en) begin
          serve_d = serve_q - 8'd1;
          if (serve_q == 8'd1) begin
            state_d = ST_PLAY;
            div_d   = 6'd0;
          end
        end
      end

      ST_PLAY: begin
        if (frame_en) begin
          if (div_q == DIV_LAST) begin
            div_d     = 6'd0;
            game_tick = 1'b1;
          end else begin
            div_d = div_q + 6'd1;
          end
        end

        case (step_q)
          SS_WAIT: begin
            if (game_tick) begin
              step_d    = SS_PAD;
              pad_req_d = 1'b1;
            end
          end
          SS_PAD: begin
            if (pad_req_q && dp.pad_ack) begin
              pad_req_d  = 1'b0;
              ball_req_d = 1'b1;
              step_d     = SS_BALL;
            end
          end
          SS_BALL: begin
            // Exit flags are only meaningful in the ball_ack cycle.
            if (ball_req_q && dp.ball_ack) begin
              ball_req_d = 1'b0;
              if (dp.ball_out_l || dp.ball_out_r) begin
                pt_l_d  = dp.ball_out_l;
                pt_r_d  = dp.ball_out_r;
                state_d = ST_POINT;
                step_d  = SS_WAIT;
              end else begin
                ai_req_d = 1'b1;
                step_d   = SS_AI;
              end
            end
          end
          SS_AI: begin
            if (ai_req_q && dp.ai_ack) begin
              ai_req_d = 1'b0;
              step_d   = SS_WAIT;
            end
          end
          default: step_d = SS_WAIT;
        endcase

        if (game_tick && (step_q != SS_WAIT)) begin
          tick_overrun_d = 1'b1;
        end
      end

      ST_POINT: begin
        // A simultaneous exit on both sides scores nothing and re-serves.
        state_d = ST_SERVE;
        serve_d = SERVE_LOAD;
        if (pt_l_q && !pt_r_q) begin
          score_d[3:0] = nib_p;
          if (nib_p == WIN_NIB) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end
        end else if (pt_r_q && !pt_l_q) begin
          score_d[7:4] = nib_o;
          if (nib_o == WIN_NIB) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end
        end
      end

      ST_OVER: begin
        if (start_rise) begin
          score_d     = 8'h00;
          game_over_d = 1'b0;
          serve_d     = SERVE_LOAD;
          state_d     = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ball_center_d = (state_d != ST_PLAY);
  end

  // Register all state and outputs; synchronous reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      step_q         <= SS_WAIT;
      div_q          <= 6'd0;
      serve_q        <= 8'd0;
      start_q        <= 1'b0;
      pad_req_q      <= 1'b0;
      ball_req_q     <= 1'b0;
      ai_req_q       <= 1'b0;
      ball_center_q  <= 1'b1;
      score_q        <= 8'h00;
      game_over_q    <= 1'b0;
      tick_overrun_q <= 1'b0;
      pt_l_q         <= 1'b0;
      pt_r_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      div_q          <= div_d;
      serve_q        <= serve_d;
      start_q        <= start_d;
      pad_req_q      <= pad_req_d;
      ball_req_q     <= ball_req_d;
      ai_req_q       <= ai_req_d;
      ball_center_q  <= ball_center_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
      tick_overrun_q <= tick_overrun_d;
      pt_l_q         <= pt_l_d;
      pt_r_q         <= pt_r_d;
    end
  end

  assign dp.pad_req   = pad_req_q;
  assign dp.ball_req  = ball_req_q;
  assign dp.ai_req    = ai_req_q;
  assign ball_center  = ball_center_q;
  assign score        = score_q;
  assign game_over    = game_over_q;
  assign state        = state_q;
  assign tick_overrun = tick_overrun_q;

endmodule
